// File: rtl/scan_bridge_pkg.sv
// scan_bridge_pkg: shared FSM state type, scan chain field offsets and chain length.
package scan_bridge_pkg;
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_RD, S_DONE} state_t;
    localparam int OFF_WEN  = 0;
    localparam int OFF_REN  = 1;
    localparam int OFF_AINC = 2;
    localparam int OFF_ADDR = 3;
    function automatic int off_wdata(input int aw);
        return OFF_ADDR + aw;
    endfunction
    function automatic int off_rdata(input int aw, input int dw);
        return off_wdata(aw) + dw;
    endfunction
    function automatic int off_ready(input int aw, input int dw);
        return off_rdata(aw, dw) + dw;
    endfunction
    function automatic int off_err(input int aw, input int dw);
        return off_ready(aw, dw) + 1;
    endfunction
    function automatic int chain_len(input int aw, input int dw);
        return off_err(aw, dw) + 1;
    endfunction
endpackage

// File: rtl/scan_bus_bridge_sync.sv
// scan_sync: 2-flop synchronizer for one host scan pin plus toggle detect on the synced copy.
module scan_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_level,
    output logic o_edge
);
    logic r_meta, r_sync, r_prev;
    always_ff @(posedge clk or posedge rst)
        if (rst) {r_meta, r_sync, r_prev} <= '0;
        else     {r_meta, r_sync, r_prev} <= {i_d, r_meta, r_sync};
    assign o_level = r_sync;
    assign o_edge  = r_sync ^ r_prev;
endmodule

// File: rtl/scan_bus_bridge.sv
// scan_bus_bridge: host scan chain driving single-beat bus reads/writes with
// auto-increment, read timeout and status readback through the same chain.
module scan_bus_bridge
    import scan_bridge_pkg::*;
#(
    parameter int ADDR_W    = 20,
    parameter int DATA_W    = 32,
    parameter int ADDR_STEP = 1,
    parameter int TIMEOUT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scan_phi,
    input  logic              scan_phi_bar,
    input  logic              scan_data_in,
    input  logic              scan_load_chip,
    input  logic              scan_load_chain,
    input  logic              scan_id,
    output logic              scan_data_out,
    output logic              bus_valid,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ready,
    input  logic              bus_rvalid,
    input  logic [DATA_W-1:0] bus_rdata
);
    localparam int L    = chain_len(ADDR_W, DATA_W);
    localparam int O_WD = off_wdata(ADDR_W);
    localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'((1 << TIMEOUT_W) - 2);
    localparam logic [ADDR_W-1:0]    STEP     = ADDR_W'(ADDR_STEP);

    logic [5:0] w_async, w_lvl, w_edge;
    logic       w_phi_rise, w_phibar_rise, w_chip_rise, w_id_tog, w_unused;

    assign w_async = {scan_id, scan_load_chain, scan_load_chip, scan_data_in, scan_phi_bar, scan_phi};
    for (genvar i = 0; i < 6; i++) begin : g_sync
        scan_sync u_sync (.clk(clk), .rst(rst), .i_d(w_async[i]), .o_level(w_lvl[i]), .o_edge(w_edge[i]));
    end
    assign w_phi_rise    = w_edge[0] & w_lvl[0];
    assign w_phibar_rise = w_edge[1] & w_lvl[1];
    assign w_chip_rise   = w_edge[3] & w_lvl[3];
    assign w_id_tog      = w_edge[5];
    assign w_unused      = ^{w_edge[2], w_edge[4], w_lvl[5]};

    logic [L-1:0]         r_chain;
    logic                 r_master;
    logic                 r_wen, r_ren, r_autoinc, r_ready, r_err;
    logic [ADDR_W-1:0]    r_addr;
    logic [DATA_W-1:0]    r_wdata, r_rdata;
    logic [TIMEOUT_W-1:0] r_tmo;
    state_t               r_state;
    logic                 r_bus_valid, r_bus_we;
    logic [ADDR_W-1:0]    r_bus_addr;
    logic [DATA_W-1:0]    r_bus_wdata;

    assign scan_data_out = r_chain[0];
    assign bus_valid     = r_bus_valid;
    assign bus_we        = r_bus_we;
    assign bus_addr      = r_bus_addr;
    assign bus_wdata     = r_bus_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_master <= 1'b0;
            r_chain  <= '0;
        end else begin
            if (w_phi_rise)
                r_master <= w_lvl[2];
            if (w_phibar_rise)
                r_chain <= w_lvl[4] ? {r_err, r_ready, r_rdata, r_wdata, r_addr, r_autoinc, r_ren, r_wen}
                                    : {r_master, r_chain[L-1:1]};
        end
    end

    // Flag updates from the FSM are written after load_chip so completion wins a same-cycle tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {r_wen, r_ren, r_autoinc, r_ready, r_err} <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_tmo       <= '0;
            r_state     <= S_IDLE;
            r_bus_valid <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
        end else begin
            if (w_chip_rise) begin
                r_wen     <= r_chain[OFF_WEN];
                r_ren     <= r_chain[OFF_REN];
                r_autoinc <= r_chain[OFF_AINC];
                r_addr    <= r_chain[OFF_ADDR +: ADDR_W];
                r_wdata   <= r_chain[O_WD +: DATA_W];
                r_ready   <= 1'b0;
                r_err     <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_id_tog && (r_wen ^ r_ren)) begin
                        r_state     <= S_ISSUE;
                        r_bus_valid <= 1'b1;
                        r_bus_we    <= r_wen;
                        r_bus_addr  <= r_addr;
                        r_bus_wdata <= r_wdata;
                    end else if (w_id_tog && r_wen && r_ren) begin
                        r_err   <= 1'b1;
                        r_ready <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (bus_ready) begin
                        r_bus_valid <= 1'b0;
                        r_tmo       <= '0;
                        r_state     <= r_bus_we ? S_DONE : S_WAIT_RD;
                    end
                end
                S_WAIT_RD: begin
                    r_tmo <= r_tmo + 1'b1;
                    if (bus_rvalid) begin
                        r_rdata <= bus_rdata;
                        r_state <= S_DONE;
                    end else if (r_tmo == TMO_LAST) begin
                        r_err   <= 1'b1;
                        r_rdata <= '0;
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_ready <= 1'b1;
                    r_addr  <= r_autoinc ? r_addr + STEP : r_addr;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/scan_bus_bridge.md
SCAN_BUS_BRIDGE -- requirements
Module: scan_bus_bridge

Interface
REQ-001 Parameter ADDR_W, default 20: bus address width.
REQ-002 Parameter DATA_W, default 32: bus data width.
REQ-003 Parameter ADDR_STEP, default 1: auto-increment stride added to the address.
REQ-004 Parameter TIMEOUT_W, default 8: width of the read-timeout counter; timeout fires at 2^TIMEOUT_W-1 cycles.
REQ-005 Port clk, input, 1: the single clock; all logic SHALL be synchronous to it.
REQ-006 Port rst, input, 1: reset, asynchronous, active-high.
REQ-007 Ports scan_phi, scan_phi_bar, scan_data_in, scan_load_chip, scan_load_chain, scan_id: inputs, 1 bit each, asynchronous to clk (host scan pins).
REQ-008 Port scan_data_out, output, 1: chain bit 0.
REQ-009 Ports bus_valid, bus_we (outputs, 1); bus_addr (output, ADDR_W); bus_wdata (output, DATA_W): request channel.
REQ-010 Port bus_ready, input, 1: request accepted when bus_valid and bus_ready are both high.
REQ-011 Ports bus_rvalid (input, 1) and bus_rdata (input, DATA_W): read response.

Function
REQ-012 Every scan input SHALL pass through a 2-flop synchronizer; edges SHALL be detected on the synchronized copies.
REQ-013 Chain length L = 5+ADDR_W+2*DATA_W (89 at defaults), LSB first: [0] wen, [1] ren, [2] autoinc, then addr, wdata, rdata, ready, err.
REQ-014 A rising edge of synced scan_phi SHALL capture scan_data_in into a master bit.
REQ-015 On a rising edge of synced scan_phi_bar with load_chain low, chain <= {master, chain[L-1:1]}.
REQ-016 On a rising edge of synced scan_phi_bar with load_chain high, the chain SHALL parallel-load the live config and status: wen, ren, autoinc, current addr, wdata, rdata, ready, err.
REQ-017 A rising edge of synced scan_load_chip SHALL copy the chain's wen, ren, autoinc, addr and wdata fields into the config registers, and SHALL clear ready and err.
REQ-018 Any edge (toggle) of synced scan_id SHALL trigger one transaction from the config registers when the FSM is IDLE; a toggle in any other state SHALL be ignored.
REQ-019 FSM states: IDLE, ISSUE, WAIT_RD, DONE.
REQ-020 IDLE, toggle, wen xor ren: go to ISSUE.
REQ-021 IDLE, toggle, wen and ren both high: set err and ready, no bus activity, stay in IDLE.
REQ-022 IDLE, toggle, wen and ren both low: no operation, no flag change.
REQ-023 In ISSUE, bus_valid is high and bus_addr/bus_we/bus_wdata are held stable until bus_ready.
REQ-024 On acceptance, a write SHALL go to DONE and a read SHALL go to WAIT_RD.
REQ-025 In WAIT_RD, the first bus_rvalid SHALL latch bus_rdata into rdata and go to DONE.
REQ-026 WAIT_RD with no bus_rvalid for 2^TIMEOUT_W-1 cycles: set err, rdata=0, go to DONE.
REQ-027 DONE, single cycle: set ready; if autoinc, addr <= addr+ADDR_STEP (modulo 2^ADDR_W, wraps); return to IDLE.
REQ-028 Latency: bus_valid SHALL rise 1 cycle after the synchronized scan_id edge is detected.
REQ-029 bus_rvalid outside WAIT_RD SHALL be ignored.

Reset
REQ-030 While rst is high: chain, master, config, rdata, ready, err, synchronizers and timeout counter SHALL be 0.
REQ-031 While rst is high: FSM in IDLE; bus_valid=0, bus_we=0, bus_addr=0, bus_wdata=0, scan_data_out=0.
REQ-032 Synchronizer edge detectors SHALL not report an edge on the first cycle after reset deassertion.
REQ-033 Reset asserted mid-transaction SHALL drop bus_valid immediately, with no completion flag.

Structure
REQ-034 A shared package scan_bridge_pkg SHALL hold: the FSM state enum, chain field offset constants as functions of ADDR_W/DATA_W, and the chain-length function.
REQ-035 One sub-module, scan_sync (2-flop synchronizer plus edge detect), SHALL be instantiated per scan input.

Verification
REQ-036 Write: shift wen=1, addr=0x00480, wdata=0x1, load_chip, toggle scan_id -> one bus_valid/bus_we beat with addr 0x00480 and data 0x1; then load_chain plus shift -> ready=1, err=0.
REQ-037 Read: ren=1, addr=0x00002, bus returns 0x13579876 after 3 cycles -> shifted-out rdata=0x13579876, ready=1.
REQ-038 Auto-increment: autoinc=1, addr=0xFFFFF, four write toggles with new wdata each -> bus addresses 0xFFFFF, 0x00000, 0x00001, 0x00002.
REQ-039 Timeout: read, bus_rvalid never asserted -> after 255 cycles err=1, rdata=0, FSM back in IDLE.
REQ-040 Illegal and busy: wen=ren=1 -> no bus_valid, err=1; bus_ready held low 50 cycles with an extra scan_id toggle -> exactly one transaction.
REQ-041 Reset mid-ISSUE -> bus_valid=0 within the same cycle; all shifted-out status bits 0.
